// File: rtl/long_multiplier_sequencer.sv
// Iterative unsigned DATA_WIDTH x DATA_WIDTH multiplier: one shared product row
// evaluated once per cycle for DATA_WIDTH cycles, with valid/ready on both sides.

module long_multiplier_product_row #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] and_product,
  input  logic [DATA_WIDTH-2:0] partial_product,
  input  logic                  prev_carry,
  output logic                  product_bit,
  output logic [DATA_WIDTH-2:0] result,
  output logic                  carry
);
  logic [DATA_WIDTH:0] sum;

  // {prev_carry, partial_product} is the upper part of the running sum, already
  // shifted down by one bit relative to the previous row.
  assign sum         = {1'b0, and_product} + {1'b0, prev_carry, partial_product};
  assign product_bit = sum[0];
  assign result      = sum[DATA_WIDTH-1:1];
  assign carry       = sum[DATA_WIDTH];
endmodule

// Handshake: an operand pair moves on an edge where valid_i & ready_o; a product
// moves on an edge where valid_o & ready_i. valid_o holds with product_o stable
// until taken, and ready_o is high only while idle.
module long_multiplier_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH-1:0]   multiplicand_i,
  input  logic [DATA_WIDTH-1:0]   multiplier_i,
  output logic [2*DATA_WIDTH-1:0] product_o,
  output logic                    valid_o,
  input  logic                    ready_i
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-2:0] partial_q;
  logic                  carry_q;
  logic [DATA_WIDTH-2:0] low_q;
  logic [CW-1:0]         count_q;

  logic                  row_bit;
  logic [DATA_WIDTH-2:0] row_result;
  logic                  row_carry;
  logic                  last_row;

  long_multiplier_product_row #(.DATA_WIDTH(DATA_WIDTH)) u_row (
    .and_product     (a_q & {DATA_WIDTH{b_q[0]}}),
    .partial_product (partial_q),
    .prev_carry      (carry_q),
    .product_bit     (row_bit),
    .result          (row_result),
    .carry           (row_carry)
  );

  assign last_row = (count_q == CW'(DATA_WIDTH - 1));
  assign ready_o  = (state_q == IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i)  state_d = COMPUTE;
      COMPUTE: if (last_row) state_d = DONE;
      DONE:    if (ready_i)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q       <= '0;
      b_q       <= '0;
      partial_q <= '0;
      carry_q   <= 1'b0;
      low_q     <= '0;
      count_q   <= '0;
      product_o <= '0;
      valid_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            a_q       <= multiplicand_i;
            b_q       <= multiplier_i;
            partial_q <= '0;
            carry_q   <= 1'b0;
            count_q   <= '0;
          end
        end
        COMPUTE: begin
          partial_q <= row_result;
          carry_q   <= row_carry;
          low_q     <= {row_bit, low_q[DATA_WIDTH-2:1]};
          b_q       <= b_q >> 1;
          count_q   <= count_q + 1'b1;
          // low_q already holds product bits DATA_WIDTH-2..0, LSB at index 0.
          if (last_row) begin
            product_o <= {row_carry, row_result, row_bit, low_q};
            valid_o   <= 1'b1;
          end
        end
        DONE: begin
          if (ready_i) valid_o <= 1'b0;
        end
        default: valid_o <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_long_multiplier_sequencer.sv
// Scoreboard bench for long_multiplier_sequencer: directed cases plus randomized
// operands with random downstream back-pressure, checked against plain A*B.

module tb_long_multiplier_sequencer;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           valid_i = 1'b0;
  logic           ready_i = 1'b1;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           ready_o;
  logic           valid_o;
  logic [2*W-1:0] product;

  long_multiplier_sequencer #(.DATA_WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .multiplicand_i (a),
    .multiplier_i   (b),
    .product_o      (product),
    .valid_o        (valid_o),
    .ready_i        (ready_i)
  );

  always #5 clk = ~clk;

  int             tests = 0;
  int             fails = 0;
  int             cyc = 0;
  int             rdy_mode = 0;
  logic [2*W-1:0] exp_q[$];
  int             acc_q[$];
  bit             in_hold = 1'b0;
  logic [2*W-1:0] held = '0;
  logic [2*W-1:0] last_prod = '0;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xx, yy;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    return xx * yy;
  endfunction

  function automatic void chk(input string name, input logic [2*W-1:0] act,
                              input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Input side of the scoreboard: an accepted pair pushes its expected product.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (valid_i && ready_o) begin
        exp_q.push_back(model(a, b));
        acc_q.push_back(cyc);
      end
      if (valid_o && ready_i) in_hold = 1'b0;
    end
  end

  // Output side: pop on each new result, then watch it stay put until taken.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && !in_hold) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 64'(valid_o), 64'(0));
        end else begin
          held = exp_q.pop_front();
          chk("product", product, held);
          chk("latency", 64'(cyc - acc_q.pop_front()), 64'(W));
          in_hold   = 1'b1;
          last_prod = held;
        end
      end else if (in_hold) begin
        chk("valid_held", 64'(valid_o), 64'(1));
        chk("product_held", product, held);
        if (!valid_o) in_hold = 1'b0;
      end else begin
        chk("product_kept", product, last_prod);
      end
      chk("ready_o", 64'(ready_o), 64'(exp_q.size() == 0 && !in_hold));
    end
  end

  always @(negedge clk) begin
    if (rdy_mode == 1) ready_i = 1'($urandom_range(0, 1));
  end

  task automatic apply_reset();
    rst_n   = 1'b0;
    valid_i = 1'b1;
    a       = $urandom;
    b       = $urandom;
    exp_q.delete();
    acc_q.delete();
    in_hold   = 1'b0;
    last_prod = '0;
    #1;
    chk("reset_valid", 64'(valid_o), 64'(0));
    chk("reset_product", product, 64'(0));
    chk("reset_ready", 64'(ready_o), 64'(1));
    repeat (2) @(negedge clk);
    valid_i = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    valid_i = 1'b1;
    a = x;
    b = y;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      ok = ready_o && rst_n;
      if (ok) break;
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
    @(negedge clk);
    valid_i = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic pulse(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    valid_i = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      idle = (exp_q.size() == 0) && !in_hold;
      if (idle) break;
    end
    if (!idle) chk("idle_timeout", 64'(idle), 64'(1));
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      seen = valid_o;
      if (seen) break;
    end
    if (!seen) chk("valid_timeout", 64'(seen), 64'(1));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    apply_reset();

    // Maximum 8-bit operands, downstream always ready.
    rdy_mode = 0;
    ready_i  = 1'b1;
    send(32'hFF, 32'hFF);
    wait_idle();

    // Two back-to-back pairs, including a zero multiplicand.
    send(32'h80, 32'h02);
    send(32'h00, 32'hA5);
    wait_idle();

    // Back-pressure: result must hold for five cycles.
    ready_i = 1'b0;
    send(32'h0D, 32'h0B);
    wait_valid();
    repeat (5) @(negedge clk);
    ready_i = 1'b1;
    wait_idle();

    // valid_i pulses while busy must be ignored.
    send(32'h03, 32'h05);
    repeat (3) @(negedge clk);
    pulse(32'h01, 32'h01);
    pulse(W'($urandom), W'($urandom));
    wait_idle();

    // Asynchronous reset part-way through an operation.
    send(32'h55, 32'h66);
    repeat (4) @(posedge clk);
    #2;
    apply_reset();
    send(32'h12, 32'h34);
    wait_idle();

    // Full-width corner.
    send('1, '1);
    wait_idle();

    // Randomized operands with random back-pressure.
    rdy_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      send(rand_operand(), rand_operand());
      if ($urandom_range(0, 3) == 0) pulse(W'($urandom), W'($urandom));
    end
    wait_idle();
    rdy_mode = 0;
    ready_i  = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
